// File: rtl/instruction_cache_controller.sv
// Direct-mapped instruction cache between the fetch stage and main memory.
// Hits answer in the cycle after acceptance. Misses fetch one 128-bit block
// and refill the line. A flush clears every valid bit and cancels any
// response that is still pending.
module instruction_cache_controller #(
  parameter int SATIR_SAYISI = 16,
  parameter int ADRES_BIT    = 32,
  parameter int BLOK_BIT     = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADRES_BIT-1:0] getir_istek_adres_i,
  input  logic                 getir_istek_gecerli_i,
  output logic                 getir_istek_hazir_o,
  output logic [31:0]          getir_buyruk_o,
  output logic                 getir_buyruk_gecerli_o,
  input  logic                 getir_temizle_i,
  output logic [ADRES_BIT-1:0] denetleyici_okuma_istek_adres_o,
  output logic                 denetleyici_okuma_istek_gecerli_o,
  input  logic [BLOK_BIT-1:0]  denetleyici_okuma_veri_blok_i,
  input  logic                 denetleyici_okuma_istek_hazir_i
);

  localparam int IDX   = $clog2(SATIR_SAYISI);
  localparam int TAG_W = ADRES_BIT - IDX - 4;

  typedef enum logic [2:0] {
    BOSTA,
    SORGU,
    BELLEK_ISTE,
    BELLEK_BEKLE,
    YANIT
  } durum_t;

  // Control state
  durum_t                state_q, state_d;
  logic [ADRES_BIT-1:2]  adres_q, adres_d;
  logic [31:0]           buyruk_q, buyruk_d;
  logic                  abort_q, abort_d;
  logic                  mem_req_q, mem_req_d;
  logic [SATIR_SAYISI-1:0] valid_q, valid_d;

  // Line storage
  logic [TAG_W-1:0]    line_tag_q  [SATIR_SAYISI];
  logic [BLOK_BIT-1:0] line_data_q [SATIR_SAYISI];

  // Fetch bits [1:0] only select bytes within a word and are not needed.
  logic unused_byte_bits;
  assign unused_byte_bits = ^getir_istek_adres_i[1:0];

  // Field split of the registered request address
  logic [IDX-1:0]   idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  assign idx = adres_q[IDX+3:4];
  assign tag = adres_q[ADRES_BIT-1:IDX+4];
  assign off = adres_q[3:2];

  logic        hit;
  logic [31:0] hit_word;
  logic [31:0] fill_word;
  assign hit       = valid_q[idx] && (line_tag_q[idx] == tag);
  assign hit_word  = line_data_q[idx][{off, 5'b0} +: 32];
  assign fill_word = denetleyici_okuma_veri_blok_i[{off, 5'b0} +: 32];

  logic        hazir;
  logic        accept;
  logic        resp_valid;
  logic [31:0] resp_word;
  logic        fill_we;

  // Ready is withheld during a flush and on a miss, so a flush always wins over a new request.
  assign hazir  = !getir_temizle_i &&
                  ((state_q == BOSTA) || ((state_q == SORGU) && hit));
  assign accept = getir_istek_gecerli_i && hazir;

  // Next-state, response and fill decisions
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    adres_d    = accept ? getir_istek_adres_i[ADRES_BIT-1:2] : adres_q;
    buyruk_d   = buyruk_q;
    abort_d    = abort_q;
    valid_d    = valid_q;
    fill_we    = 1'b0;
    resp_valid = 1'b0;
    resp_word  = buyruk_q;

    unique case (state_q)
      BOSTA: begin
        if (accept) state_d = SORGU;
      end
      SORGU: begin
        if (getir_temizle_i) begin
          state_d = BOSTA;
        end else if (hit) begin
          resp_valid = 1'b1;
          resp_word  = hit_word;
          buyruk_d   = hit_word;
          state_d    = accept ? SORGU : BOSTA;
        end else begin
          state_d = BELLEK_ISTE;
        end
      end
      BELLEK_ISTE: begin
        // The request pulse goes out regardless; a flush only marks the fill as dead.
        if (getir_temizle_i) abort_d = 1'b1;
        state_d = BELLEK_BEKLE;
      end
      BELLEK_BEKLE: begin
        if (getir_temizle_i) abort_d = 1'b1;
        if (denetleyici_okuma_istek_hazir_i) begin
          if (abort_q || getir_temizle_i) begin
            abort_d = 1'b0;
            state_d = BOSTA;
          end else begin
            fill_we      = 1'b1;
            valid_d[idx] = 1'b1;
            buyruk_d     = fill_word;
            state_d      = YANIT;
          end
        end
      end
      YANIT: begin
        resp_valid = !getir_temizle_i;
        state_d    = BOSTA;
      end
      default: state_d = BOSTA;
    endcase

    if (getir_temizle_i) valid_d = '0;

    mem_req_d = (state_d == BELLEK_ISTE);
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q   <= BOSTA;
      adres_q   <= '0;
      buyruk_q  <= '0;
      abort_q   <= 1'b0;
      mem_req_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      adres_q   <= adres_d;
      buyruk_q  <= buyruk_d;
      abort_q   <= abort_d;
      mem_req_q <= mem_req_d;
      valid_q   <= valid_d;
    end
  end

  // Tag and data arrays, written on a committed fill
  always_ff @(posedge clk_i) begin
    // NOTE: tag/data arrays are not reset; the valid bits alone decide whether a line is usable.
    if (fill_we) begin
      line_tag_q[idx]  <= tag;
      line_data_q[idx] <= denetleyici_okuma_veri_blok_i;
    end
  end

  assign getir_istek_hazir_o               = hazir;
  assign getir_buyruk_o                    = resp_word;
  assign getir_buyruk_gecerli_o            = resp_valid;
  assign denetleyici_okuma_istek_gecerli_o = mem_req_q;
  assign denetleyici_okuma_istek_adres_o   = {adres_q[ADRES_BIT-1:4], 4'b0};

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed bench for instruction_cache_controller: cold miss, hits, word
// select, conflict eviction, flush handling and reset in the middle of a miss.
module tb_instruction_cache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  getir_istek_adres_i;
  logic         getir_istek_gecerli_i;
  logic         getir_istek_hazir_o;
  logic [31:0]  getir_buyruk_o;
  logic         getir_buyruk_gecerli_o;
  logic         getir_temizle_i;
  logic [31:0]  denetleyici_okuma_istek_adres_o;
  logic         denetleyici_okuma_istek_gecerli_o;
  logic [127:0] denetleyici_okuma_veri_blok_i;
  logic         denetleyici_okuma_istek_hazir_i;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] BLK0 = {32'h15ef0e93, 32'h40360f33, 32'h008381b3, 32'h00940633};
  localparam logic [127:0] BLK1 = {32'h0235cb33, 32'h03158ab3, 32'h003589b3, 32'h40c288b3};
  localparam logic [127:0] BLK2 = {32'haaaa0003, 32'haaaa0002, 32'haaaa0001, 32'haaaa0000};
  localparam logic [127:0] BLK3 = {32'hdeadbe03, 32'hdeadbe02, 32'hdeadbe01, 32'hdeadbe00};
  localparam logic [127:0] BLK4 = {32'h0c0c0c03, 32'h0c0c0c02, 32'h0c0c0c01, 32'h0c0c0c00};

  instruction_cache_controller dut (
    .clk_i                             (clk_i),
    .rst_i                             (rst_i),
    .getir_istek_adres_i               (getir_istek_adres_i),
    .getir_istek_gecerli_i             (getir_istek_gecerli_i),
    .getir_istek_hazir_o               (getir_istek_hazir_o),
    .getir_buyruk_o                    (getir_buyruk_o),
    .getir_buyruk_gecerli_o            (getir_buyruk_gecerli_o),
    .getir_temizle_i                   (getir_temizle_i),
    .denetleyici_okuma_istek_adres_o   (denetleyici_okuma_istek_adres_o),
    .denetleyici_okuma_istek_gecerli_o (denetleyici_okuma_istek_gecerli_o),
    .denetleyici_okuma_veri_blok_i     (denetleyici_okuma_veri_blok_i),
    .denetleyici_okuma_istek_hazir_i   (denetleyici_okuma_istek_hazir_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; land just after the edge so outputs have settled.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a fetch in BOSTA, let it be accepted, and stop in the SORGU cycle.
  task automatic fetch_req(input logic [31:0] addr, input string tag);
    getir_istek_adres_i   = addr;
    getir_istek_gecerli_i = 1'b1;
    #1;
    check({tag, " hazir"}, {31'b0, getir_istek_hazir_o}, 32'd1);
    cyc();
    getir_istek_gecerli_i = 1'b0;
    #1;
  endtask

  // Full miss: request pulse, memory latency of lat extra cycles, then response.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] exp_adres,
                         input logic [127:0] blk, input logic [31:0] exp_word,
                         input int lat, input string tag);
    fetch_req(addr, tag);
    check({tag, " sorgu_gecerli"}, {31'b0, getir_buyruk_gecerli_o}, 32'd0);
    check({tag, " sorgu_hazir"}, {31'b0, getir_istek_hazir_o}, 32'd0);
    cyc();
    check({tag, " istek_pulse"}, {31'b0, denetleyici_okuma_istek_gecerli_o}, 32'd1);
    check({tag, " istek_adres"}, denetleyici_okuma_istek_adres_o, exp_adres);
    cyc();
    check({tag, " istek_tek"}, {31'b0, denetleyici_okuma_istek_gecerli_o}, 32'd0);
    repeat (lat) cyc();
    denetleyici_okuma_veri_blok_i   = blk;
    denetleyici_okuma_istek_hazir_i = 1'b1;
    cyc();
    denetleyici_okuma_istek_hazir_i = 1'b0;
    #1;
    check({tag, " yanit_gecerli"}, {31'b0, getir_buyruk_gecerli_o}, 32'd1);
    check({tag, " yanit_buyruk"}, getir_buyruk_o, exp_word);
    cyc();
    check({tag, " sonra_gecerli"}, {31'b0, getir_buyruk_gecerli_o}, 32'd0);
    check({tag, " sonra_hazir"}, {31'b0, getir_istek_hazir_o}, 32'd1);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i                           = 1'b1;
    getir_istek_adres_i             = '0;
    getir_istek_gecerli_i           = 1'b0;
    getir_temizle_i                 = 1'b0;
    denetleyici_okuma_veri_blok_i   = '0;
    denetleyici_okuma_istek_hazir_i = 1'b0;
    repeat (2) cyc();
    rst_i = 1'b0;
    #1;

    // Reset values
    check("rst hazir", {31'b0, getir_istek_hazir_o}, 32'd1);
    check("rst gecerli", {31'b0, getir_buyruk_gecerli_o}, 32'd0);
    check("rst istek", {31'b0, denetleyici_okuma_istek_gecerli_o}, 32'd0);
    check("rst adres", denetleyici_okuma_istek_adres_o, 32'h0);
    check("rst buyruk", getir_buyruk_o, 32'h0);

    // Cold miss at 0x0
    do_miss(32'h0, 32'h0, BLK0, 32'h00940633, 0, "cold");

    // Back-to-back hits on the filled line
    getir_istek_adres_i   = 32'h4;
    getir_istek_gecerli_i = 1'b1;
    cyc();
    getir_istek_adres_i = 32'h8;
    #1;
    check("hit4 gecerli", {31'b0, getir_buyruk_gecerli_o}, 32'd1);
    check("hit4 buyruk", getir_buyruk_o, 32'h008381b3);
    check("hit4 hazir", {31'b0, getir_istek_hazir_o}, 32'd1);
    cyc();
    getir_istek_adres_i = 32'hC;
    #1;
    check("hit8 gecerli", {31'b0, getir_buyruk_gecerli_o}, 32'd1);
    check("hit8 buyruk", getir_buyruk_o, 32'h40360f33);
    check("hit8 istek", {31'b0, denetleyici_okuma_istek_gecerli_o}, 32'd0);
    cyc();
    getir_istek_gecerli_i = 1'b0;
    #1;
    check("hitC gecerli", {31'b0, getir_buyruk_gecerli_o}, 32'd1);
    check("hitC buyruk", getir_buyruk_o, 32'h15ef0e93);
    cyc();
    check("hit end gecerli", {31'b0, getir_buyruk_gecerli_o}, 32'd0);
    check("hit end istek", {31'b0, denetleyici_okuma_istek_gecerli_o}, 32'd0);
    check("hit hold buyruk", getir_buyruk_o, 32'h15ef0e93);

    // Word select on a miss; byte bits ignored
    do_miss(32'h1E, 32'h10, BLK1, 32'h0235cb33, 2, "wsel");

    // Conflict eviction on index 0
    do_miss(32'h100, 32'h100, BLK2, 32'haaaa0000, 1, "evict100");
    do_miss(32'h0, 32'h0, BLK0, 32'h00940633, 0, "evict000");

    // Line 1 unaffected by index-0 traffic
    fetch_req(32'h14, "hit14");
    check("hit14 gecerli", {31'b0, getir_buyruk_gecerli_o}, 32'd1);
    check("hit14 buyruk", getir_buyruk_o, 32'h003589b3);
    cyc();

    // Flush while waiting for memory
    fetch_req(32'h20, "fl");
    cyc();
    check("fl istek_pulse", {31'b0, denetleyici_okuma_istek_gecerli_o}, 32'd1);
    check("fl istek_adres", denetleyici_okuma_istek_adres_o, 32'h20);
    cyc();
    getir_temizle_i = 1'b1;
    #1;
    check("fl hazir", {31'b0, getir_istek_hazir_o}, 32'd0);
    cyc();
    getir_temizle_i = 1'b0;
    cyc();
    denetleyici_okuma_veri_blok_i   = BLK3;
    denetleyici_okuma_istek_hazir_i = 1'b1;
    cyc();
    denetleyici_okuma_istek_hazir_i = 1'b0;
    #1;
    check("fl no_yanit", {31'b0, getir_buyruk_gecerli_o}, 32'd0);
    check("fl bosta_hazir", {31'b0, getir_istek_hazir_o}, 32'd1);
    cyc();
    check("fl no_yanit2", {31'b0, getir_buyruk_gecerli_o}, 32'd0);

    // Discarded fill left no line; flush also invalidated the earlier lines
    do_miss(32'h20, 32'h20, BLK3, 32'hdeadbe00, 0, "fl refetch");
    do_miss(32'h14, 32'h10, BLK1, 32'h003589b3, 0, "fl line1");

    // Flush together with a request: flush wins, then the line misses
    getir_temizle_i       = 1'b1;
    getir_istek_adres_i   = 32'h24;
    getir_istek_gecerli_i = 1'b1;
    #1;
    check("flreq hazir", {31'b0, getir_istek_hazir_o}, 32'd0);
    cyc();
    getir_temizle_i       = 1'b0;
    getir_istek_gecerli_i = 1'b0;
    #1;
    check("flreq gecerli", {31'b0, getir_buyruk_gecerli_o}, 32'd0);
    cyc();
    check("flreq no_istek", {31'b0, denetleyici_okuma_istek_gecerli_o}, 32'd0);
    do_miss(32'h24, 32'h20, BLK3, 32'hdeadbe01, 3, "after flush");

    // Reset in BELLEK_BEKLE, stale strobe two cycles later
    fetch_req(32'h30, "rm");
    cyc();
    check("rm istek_pulse", {31'b0, denetleyici_okuma_istek_gecerli_o}, 32'd1);
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    cyc();
    denetleyici_okuma_veri_blok_i   = BLK4;
    denetleyici_okuma_istek_hazir_i = 1'b1;
    cyc();
    denetleyici_okuma_istek_hazir_i = 1'b0;
    #1;
    check("rm gecerli", {31'b0, getir_buyruk_gecerli_o}, 32'd0);
    check("rm istek", {31'b0, denetleyici_okuma_istek_gecerli_o}, 32'd0);
    check("rm hazir", {31'b0, getir_istek_hazir_o}, 32'd1);
    check("rm buyruk", getir_buyruk_o, 32'h0);
    check("rm adres", denetleyici_okuma_istek_adres_o, 32'h0);
    cyc();
    check("rm idle gecerli", {31'b0, getir_buyruk_gecerli_o}, 32'd0);
    do_miss(32'h30, 32'h30, BLK4, 32'h0c0c0c00, 1, "rm refetch30");
    do_miss(32'h0, 32'h0, BLK0, 32'h00940633, 0, "rm fresh0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
